// File: rtl/inv_mix_columns_ctrl.sv
// AES-128 InvMixColumns sequencer: time-shares COLS_PER_CYCLE column multiplier
// lanes across the four state columns, with valid/ready on both sides and a bypass.
module inv_mix_columns_ctrl #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned N_COLS = 4;
  localparam int unsigned COL_W  = 32;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_columns_ctrl: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t           state, state_next;
  logic [1:0]       col_cnt, col_next;
  logic             load_mix, load_byp, calc_en, last_step;
  logic [COL_W-1:0] in_col   [N_COLS];
  logic [COL_W-1:0] work_col [N_COLS];
  logic [COL_W-1:0] res_col  [N_COLS];
  logic [1:0]       lane_col [COLS_PER_CYCLE];
  logic [COL_W-1:0] lane_out [COLS_PER_CYCLE];

  // GF(2^8) constant multipliers, polynomial 0x11B
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = c;
    return {mul14(s0) ^ mul11(s1) ^ mul13(s2) ^ mul9(s3),
            mul9(s0)  ^ mul14(s1) ^ mul11(s2) ^ mul13(s3),
            mul13(s0) ^ mul9(s1)  ^ mul14(s2) ^ mul11(s3),
            mul11(s0) ^ mul13(s1) ^ mul9(s2)  ^ mul14(s3)};
  endfunction

  for (genvar i = 0; i < N_COLS; i++) begin : g_split
    assign in_col[i] = in_data[127 - 32*i -: 32];
  end

  // One column unit per lane; lane k handles column col_cnt + k
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    assign lane_col[k] = col_cnt + 2'(k);
    assign lane_out[k] = inv_col(work_col[lane_col[k]]);
  end

  assign last_step = (col_cnt == 2'(N_COLS - COLS_PER_CYCLE));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state == CALC) || (state == HOLD);
  assign out_data  = {res_col[0], res_col[1], res_col[2], res_col[3]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
    end else begin
      state   <= state_next;
      col_cnt <= col_next;
    end
  end

  always_comb begin
    state_next = state;
    col_next   = col_cnt;
    load_mix   = 1'b0;
    load_byp   = 1'b0;
    calc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_bypass) begin
            load_byp   = 1'b1;
            state_next = HOLD;
          end else begin
            load_mix   = 1'b1;
            state_next = CALC;
            col_next   = 2'd0;
          end
        end
      end
      CALC: begin
        calc_en  = 1'b1;
        col_next = col_cnt + 2'(COLS_PER_CYCLE);
        if (last_step) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Work register latches the accepted state; result collects finished columns
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      work_col <= '{default: '0};
      res_col  <= '{default: '0};
    end else begin
      if (load_mix || load_byp) work_col <= in_col;
      if (load_byp) res_col <= in_col;
      if (calc_en) begin
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
          res_col[lane_col[k]] <= lane_out[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_ctrl.sv
// Directed bench for inv_mix_columns_ctrl with one instance per legal COLS_PER_CYCLE.
module tb_inv_mix_columns_ctrl;

  localparam logic [127:0] FIPS_I = {4{32'h8e4da1bc}};
  localparam logic [127:0] FIPS_O = {4{32'hdb135345}};
  localparam logic [127:0] MIX_I  = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] MIX_O  = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] BYP    = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic         clk, n_rst, in_bypass, out_ready;
  logic [127:0] in_data;
  logic         in_valid_v  [3];
  logic         in_ready_v  [3];
  logic         out_valid_v [3];
  logic         busy_v      [3];
  logic [127:0] out_data_v  [3];

  int n_checks = 0;
  int n_errors = 0;
  int lats [3] = '{4, 2, 1};

  inv_mix_columns_ctrl #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_data(out_data_v[0]), .busy(busy_v[0]));

  inv_mix_columns_ctrl #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_data(out_data_v[1]), .busy(busy_v[1]));

  inv_mix_columns_ctrl #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_data(out_data_v[2]), .busy(busy_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input int d, input logic [127:0] data, input logic byp);
    int n = 0;
    while (in_ready_v[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("send_ready", 128'(in_ready_v[d]), 128'd1);
    in_valid_v[d] = 1'b1;
    in_data       = data;
    in_bypass     = byp;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    in_data       = ~data;
    in_bypass     = ~byp;
  endtask

  task automatic wait_out(input int d, input int lat, input string tag);
    int n = 0;
    while (out_valid_v[d] !== 1'b1 && n < 20) begin
      check({tag, "_busy"}, 128'(busy_v[d]), 128'd1);
      check({tag, "_in_ready"}, 128'(in_ready_v[d]), 128'd0);
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(lat));
  endtask

  task automatic drain(input int d, input logic [127:0] exp, input string tag);
    check({tag, "_data"}, out_data_v[d], exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_low"}, 128'(out_valid_v[d]), 128'd0);
    check({tag, "_idle_ready"}, 128'(in_ready_v[d]), 128'd1);
    check({tag, "_idle_busy"}, 128'(busy_v[d]), 128'd0);
  endtask

  initial begin
    n_rst     = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_bypass = 1'b0;
    for (int d = 0; d < 3; d++) in_valid_v[d] = 1'b0;
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_in_ready%0d", d), 128'(in_ready_v[d]), 128'd1);
      check($sformatf("rst_out_valid%0d", d), 128'(out_valid_v[d]), 128'd0);
      check($sformatf("rst_busy%0d", d), 128'(busy_v[d]), 128'd0);
      check($sformatf("rst_out_data%0d", d), out_data_v[d], 128'd0);
    end
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 column through the single-lane instance
    send(0, FIPS_I, 1'b0);
    wait_out(0, 4, "fips");
    drain(0, FIPS_O, "fips");

    // Mixed columns on every lane width
    for (int d = 0; d < 3; d++) begin
      send(d, MIX_I, 1'b0);
      wait_out(d, lats[d], $sformatf("mix%0d", d));
      drain(d, MIX_O, $sformatf("mix%0d", d));
    end

    // Bypass: result is the input, available right after the accept edge
    send(0, BYP, 1'b1);
    wait_out(0, 0, "byp");
    drain(0, BYP, "byp");

    // Backpressure with a stray in_valid pulse while holding
    send(0, MIX_I, 1'b0);
    wait_out(0, 4, "bp");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid%0d", i), 128'(out_valid_v[0]), 128'd1);
      check($sformatf("bp_data%0d", i), out_data_v[0], MIX_O);
      check($sformatf("bp_in_ready%0d", i), 128'(in_ready_v[0]), 128'd0);
      in_valid_v[0] = (i == 3);
      in_data       = FIPS_I;
      @(posedge clk); #1;
    end
    in_valid_v[0] = 1'b0;
    drain(0, MIX_O, "bp");

    // Asynchronous reset between edges with col_cnt = 2
    send(0, FIPS_I, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 n_rst = 1'b0;
    #1;
    check("midrst_valid", 128'(out_valid_v[0]), 128'd0);
    check("midrst_data", out_data_v[0], 128'd0);
    check("midrst_busy", 128'(busy_v[0]), 128'd0);
    check("midrst_in_ready", 128'(in_ready_v[0]), 128'd1);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;
    send(0, FIPS_I, 1'b0);
    wait_out(0, 4, "postrst");
    drain(0, FIPS_O, "postrst");

    // Back-to-back with out_ready tied high (also high before out_valid)
    out_ready     = 1'b1;
    in_valid_v[0] = 1'b1;
    in_bypass     = 1'b0;
    in_data       = FIPS_I;
    @(posedge clk); #1;
    check("b2b_acc1", 128'(in_ready_v[0]), 128'd0);
    in_data = MIX_I;
    wait_out(0, 4, "b2b1");
    check("b2b1_data", out_data_v[0], FIPS_O);
    @(posedge clk); #1;
    check("b2b1_valid_low", 128'(out_valid_v[0]), 128'd0);
    check("b2b1_idle", 128'(in_ready_v[0]), 128'd1);
    @(posedge clk); #1;
    check("b2b_acc2_ready", 128'(in_ready_v[0]), 128'd0);
    check("b2b_acc2_busy", 128'(busy_v[0]), 128'd1);
    in_valid_v[0] = 1'b0;
    in_data       = '0;
    wait_out(0, 4, "b2b2");
    check("b2b2_data", out_data_v[0], MIX_O);
    @(posedge clk); #1;
    check("b2b2_valid_low", 128'(out_valid_v[0]), 128'd0);
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
